// File: rtl/approx_peak_tracker.sv
// Streaming running-maximum tracker driven by an external approximate 8-bit comparator.
// Emits one registered peak/index/count/tie summary per frame over a valid/ready stream.
module approx_peak_tracker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TIE_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic              cmp_agtb,
  input  logic              cmp_altb,
  input  logic              cmp_aeqb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_peak,
  output logic [IDX_W-1:0]  m_index,
  output logic [IDX_W-1:0]  m_count,
  output logic [TIE_W-1:0]  m_ties,
  output logic              m_ovf,
  output logic              m_cmp_err
);

  typedef enum logic [1:0] {FIRST, ACC, OUT} state_t;

  state_t            state;
  logic [DATA_W-1:0] peak_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  cnt_r;
  logic [TIE_W-1:0]  ties_r;
  logic              ovf_r;
  logic              err_r;
  logic              s_ready_r;
  logic              m_valid_r;

  logic s_acc_c;
  logic m_acc_c;
  logic cnt_sat_c;
  logic ties_sat_c;

  assign s_acc_c    = s_valid & s_ready_r;
  assign m_acc_c    = m_valid_r & m_ready;
  assign cnt_sat_c  = (cnt_r == {IDX_W{1'b1}});
  assign ties_sat_c = (ties_r == {TIE_W{1'b1}});

  // Comparator operands: incoming sample against the running peak.
  assign cmp_a = s_data;
  assign cmp_b = peak_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FIRST;
      peak_r    <= '0;
      idx_r     <= '0;
      cnt_r     <= '0;
      ties_r    <= '0;
      ovf_r     <= 1'b0;
      err_r     <= 1'b0;
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
    end else begin
      case (state)
        FIRST: begin
          if (s_acc_c) begin
            peak_r <= s_data;
            idx_r  <= '0;
            cnt_r  <= IDX_W'(1);
            ties_r <= '0;
            ovf_r  <= 1'b0;
            err_r  <= 1'b0;
            if (s_last) begin
              state     <= OUT;
              s_ready_r <= 1'b0;
              m_valid_r <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (s_acc_c) begin
            // AgtB wins over AeqB; no flag (bits 3:2 differ under an equal top nibble) keeps the peak.
            if (cmp_agtb) begin
              peak_r <= s_data;
              idx_r  <= cnt_r;
              ties_r <= '0;
            end else if (cmp_aeqb && !ties_sat_c) begin
              ties_r <= ties_r + TIE_W'(1);
            end
            if (cmp_agtb && cmp_altb) begin
              err_r <= 1'b1;
            end
            if (cnt_sat_c) begin
              ovf_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + IDX_W'(1);
            end
            if (s_last) begin
              state     <= OUT;
              s_ready_r <= 1'b0;
              m_valid_r <= 1'b1;
            end
          end
        end
        OUT: begin
          if (m_acc_c) begin
            state     <= FIRST;
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
          end
        end
        default: begin
          state     <= FIRST;
          s_ready_r <= 1'b1;
          m_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_r;
  assign m_valid   = m_valid_r;
  assign m_peak    = peak_r;
  assign m_index   = idx_r;
  assign m_count   = cnt_r;
  assign m_ties    = ties_r;
  assign m_ovf     = ovf_r;
  assign m_cmp_err = err_r;

endmodule

// File: tb/tb_approx_peak_tracker.sv
// Directed bench for approx_peak_tracker with a behavioural model of the approximate comparator.
// A second instance with IDX_W=2 shares all inputs to exercise count saturation and overflow.
module tb_approx_peak_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_ready;
  logic       inj;

  logic       s_ready, m_valid, m_ovf, m_cmp_err;
  logic [7:0] cmp_a, cmp_b, m_peak, m_index, m_count;
  logic [3:0] m_ties;
  logic       agtb, altb, aeqb;

  logic       s_ready2, m_valid2, m_ovf2, m_cmp_err2;
  logic [7:0] cmp_a2, cmp_b2, m_peak2;
  logic [1:0] m_index2, m_count2;
  logic [3:0] m_ties2;
  logic       agtb2, altb2, aeqb2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Comparator model: ordering on bits 7:4, equality ignoring bits 1:0; inj forces AgtB&AltB.
  assign agtb  = inj | (cmp_a[7:4] > cmp_b[7:4]);
  assign altb  = inj | (cmp_a[7:4] < cmp_b[7:4]);
  assign aeqb  = ~inj & (cmp_a[7:2] == cmp_b[7:2]);
  assign agtb2 = inj | (cmp_a2[7:4] > cmp_b2[7:4]);
  assign altb2 = inj | (cmp_a2[7:4] < cmp_b2[7:4]);
  assign aeqb2 = ~inj & (cmp_a2[7:2] == cmp_b2[7:2]);

  approx_peak_tracker dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_agtb(agtb), .cmp_altb(altb),
    .cmp_aeqb(aeqb), .m_valid(m_valid), .m_ready(m_ready), .m_peak(m_peak),
    .m_index(m_index), .m_count(m_count), .m_ties(m_ties), .m_ovf(m_ovf),
    .m_cmp_err(m_cmp_err)
  );

  approx_peak_tracker #(.IDX_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .cmp_a(cmp_a2), .cmp_b(cmp_b2), .cmp_agtb(agtb2), .cmp_altb(altb2),
    .cmp_aeqb(aeqb2), .m_valid(m_valid2), .m_ready(m_ready), .m_peak(m_peak2),
    .m_index(m_index2), .m_count(m_count2), .m_ties(m_ties2), .m_ovf(m_ovf2),
    .m_cmp_err(m_cmp_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic force_err);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    inj     = force_err;
    @(posedge clk);
  endtask

  // Drop s_valid and land on the first cycle after the s_last accept.
  task automatic end_frame();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    inj     = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [7:0] peak, input logic [7:0] idx,
                               input logic [7:0] cnt, input logic [3:0] ties,
                               input logic ovf, input logic err);
    chk({tag, ".valid"},  32'(m_valid), 32'd1);
    chk({tag, ".sready"}, 32'(s_ready), 32'd0);
    chk({tag, ".peak"},   32'(m_peak), 32'(peak));
    chk({tag, ".index"},  32'(m_index), 32'(idx));
    chk({tag, ".count"},  32'(m_count), 32'(cnt));
    chk({tag, ".ties"},   32'(m_ties), 32'(ties));
    chk({tag, ".ovf"},    32'(m_ovf), 32'(ovf));
    chk({tag, ".err"},    32'(m_cmp_err), 32'(err));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, ".idle_valid"},  32'(m_valid), 32'd0);
    chk({tag, ".idle_sready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    m_ready = 1'b1;
    inj     = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst.valid",  32'(m_valid), 32'd0);
    chk("rst.peak",   32'(m_peak), 32'd0);
    chk("rst.count",  32'(m_count), 32'd0);
    chk("rst.ties",   32'(m_ties), 32'd0);
    chk("rst.sready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;

    // Rise, approximate tie, then a smaller sample.
    send(8'h10, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h40; s_last = 1'b0;
    #1;
    chk("f1.cmp_a", 32'(cmp_a), 32'h40);
    chk("f1.cmp_b", 32'(cmp_b), 32'h10);
    @(posedge clk);
    send(8'h43, 1'b0, 1'b0);
    send(8'h30, 1'b1, 1'b0);
    end_frame();
    expect_result("f1", 8'h40, 8'd1, 8'd4, 4'd1, 1'b0, 1'b0);
    expect_idle("f1");

    // Bits 3:2 differ under equal top nibble: no flag, peak kept.
    send(8'h20, 1'b0, 1'b0);
    send(8'h28, 1'b1, 1'b0);
    end_frame();
    expect_result("f2", 8'h20, 8'd0, 8'd2, 4'd0, 1'b0, 1'b0);
    expect_idle("f2");

    // Comparator asserts AgtB and AltB together: error flagged, AgtB branch taken.
    send(8'h80, 1'b0, 1'b0);
    send(8'h20, 1'b1, 1'b1);
    end_frame();
    expect_result("err", 8'h20, 8'd1, 8'd2, 4'd0, 1'b0, 1'b1);
    expect_idle("err");

    // Single-sample frame also clears the previous error flag.
    send(8'h7F, 1'b1, 1'b0);
    end_frame();
    expect_result("one", 8'h7F, 8'd0, 8'd1, 4'd0, 1'b0, 1'b0);
    expect_idle("one");

    // Result stalled by m_ready low for 3 cycles.
    send(8'h05, 1'b0, 1'b0);
    send(8'h90, 1'b1, 1'b0);
    m_ready = 1'b0;
    end_frame();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall.valid",  32'(m_valid), 32'd1);
      chk("stall.sready", 32'(s_ready), 32'd0);
      chk("stall.peak",   32'(m_peak), 32'h90);
      chk("stall.index",  32'(m_index), 32'd1);
    end
    m_ready = 1'b1;
    expect_idle("stall");

    // Tie counter saturates at 15 over 16 equal hits.
    for (int i = 0; i < 17; i++) send(8'h40, (i == 16), 1'b0);
    end_frame();
    expect_result("tiesat", 8'h40, 8'd0, 8'd17, 4'd15, 1'b0, 1'b0);
    expect_idle("tiesat");

    // Five rising samples: IDX_W=2 instance saturates and overflows.
    for (int i = 0; i < 5; i++) send(8'h01 + 8'(i * 16), (i == 4), 1'b0);
    end_frame();
    expect_result("wide", 8'h41, 8'd4, 8'd5, 4'd0, 1'b0, 1'b0);
    chk("ovf.valid", 32'(m_valid2), 32'd1);
    chk("ovf.peak",  32'(m_peak2), 32'h41);
    chk("ovf.index", 32'(m_index2), 32'd3);
    chk("ovf.count", 32'(m_count2), 32'd3);
    chk("ovf.ovf",   32'(m_ovf2), 32'd1);
    expect_idle("ovf");

    // Reset mid-frame aborts the frame with no stale result.
    send(8'h50, 1'b0, 1'b0);
    send(8'h60, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("abort.valid", 32'(m_valid), 32'd0);
    chk("abort.peak",  32'(m_peak), 32'd0);
    chk("abort.count", 32'(m_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort.nostale", 32'(m_valid), 32'd0);
    send(8'h33, 1'b1, 1'b0);
    end_frame();
    expect_result("post", 8'h33, 8'd0, 8'd1, 4'd0, 1'b0, 1'b0);
    expect_idle("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/approx_peak_tracker.md
Name: approx_peak_tracker

Overview:
- Streaming running-maximum tracker; sits directly downstream of approx_comparator_8_bit and also drives its operands.
- Accepts frames of 8-bit samples over a valid/ready stream.
- Each cycle it presents the incoming sample and the current peak to the external comparator, then consumes AgtB/AeqB to update the peak, its index and an approximate-tie count.
- At frame end it emits one registered result beat to downstream scheduling logic.

Parameters:
- DATA_W, 8, sample width; fixed to match the 8-bit comparator.
- IDX_W, 8, width of sample counter and peak index.
- TIE_W, 4, width of the saturating approximate-tie counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  tracker can accept a sample.
- s_data  in  DATA_W  sample value.
- s_last  in  1  marks the final sample of a frame.
- cmp_a  out  DATA_W  comparator operand a; equals s_data, combinational.
- cmp_b  out  DATA_W  comparator operand b; equals peak_r, combinational.
- cmp_agtb  in  1  comparator AgtB.
- cmp_altb  in  1  comparator AltB; monitored only.
- cmp_aeqb  in  1  comparator AeqB.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_peak  out  DATA_W  frame peak value.
- m_index  out  IDX_W  0-based position of the peak within the frame.
- m_count  out  IDX_W  samples in the frame, saturating.
- m_ties  out  TIE_W  approximate-equal hits against the final peak, saturating.
- m_ovf  out  1  frame exceeded 2^IDX_W-1 samples.
- m_cmp_err  out  1  comparator asserted AgtB and AltB together at least once in the frame.

Behaviour:
- Reset (rst_n low, asynchronous): state=FIRST.
  - peak_r, idx_r, cnt_r, ties_r, ovf_r and err_r all clear to 0.
  - m_valid=0 and all m_* outputs are 0.
  - Deassertion is used synchronously.
- Handshake:
  - Sample accepted when s_valid & s_ready.
  - Result consumed when m_valid & m_ready.
  - m_* outputs are held stable while m_valid=1 and m_ready=0.
- FSM states: FIRST, ACC, OUT.
- FIRST (s_ready=1): on accept, peak_r<=s_data, idx_r<=0, cnt_r<=1, ties_r<=0, ovf_r<=0, err_r<=0. Comparator outputs are ignored. Next state is OUT if s_last, else ACC.
- ACC (s_ready=1): on accept, apply in priority order:
  - If cmp_agtb: peak_r<=s_data, idx_r<=cnt_r, ties_r<=0.
  - Else if cmp_aeqb: ties_r<=ties_r+1, saturating at 2^TIE_W-1.
  - Else (AltB, or no flag because bits 3:2 differ while the top nibble matches): no change to peak, index or ties.
  - If cmp_agtb & cmp_altb: err_r<=1, and the AgtB branch still applies.
  - cnt_r<=cnt_r+1, saturating at 2^IDX_W-1. If cnt_r is already at max, set ovf_r<=1; idx_r then uses the saturated value.
  - s_last moves to OUT.
- OUT (s_ready=0, m_valid=1): outputs reflect the registers after the last update. On m_ready, go to FIRST in the next cycle. There is no same-cycle accept of the next frame.
- Latency: the result is valid the cycle after the s_last accept. Throughput is one sample per cycle inside a frame, plus one bubble cycle per frame, plus any m_ready stall.
- cmp_a/cmp_b are driven in every state. The comparator path is combinational within one cycle (s_data -> comparator -> update logic).
- The tracker inherits the comparator's approximations and does not correct them: equality ignores bits [1:0], and ordering uses bits [7:4] only.
- s_valid low in FIRST/ACC causes no state change. s_data and s_last are don't-care when s_valid is low.
- Reset asserted mid-frame or during OUT aborts the frame; no result is emitted.

Test Plan:
- Frame 0x10,0x40,0x43,0x30(last), m_ready=1 -> one m_valid pulse with m_peak=0x40, m_index=1, m_count=4, m_ties=1 (0x43 is AeqB with 0x40), m_ovf=0.
- Frame 0x20,0x28(last) -> m_peak=0x20, m_index=0, m_ties=0 (no flag from the comparator; peak kept), m_count=2.
- Single-sample frame 0x7F with s_last -> m_valid the next cycle, m_peak=0x7F, m_index=0, m_count=1, m_ties=0.
- Frame 0x05,0x90(last) with m_ready held low 3 cycles -> s_ready=0 and m_peak=0x90, m_index=1 stable for all 4 valid cycles; s_ready=1 again the cycle after the handshake.
- IDX_W=2, 5 samples 0x01,0x11,0x21,0x31,0x41(last) -> m_count=3, m_ovf=1, m_peak=0x41, m_index=3.
- rst_n pulsed low after the 2nd sample of a frame -> all outputs 0 immediately; the next frame 0x33(last) yields m_peak=0x33, m_count=1, and no stale result is emitted.
